// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry elastic buffer that registers a fully decoded
// control word, immediate and register fields for the execute stage.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [21:0] ctrl,
  output logic [31:0] pc_out,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic        illegal
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SRA = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [2:0] CMP_BLT  = 3'b100;
  localparam logic [2:0] CMP_BLTU = 3'b110;

  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [2:0]  f3;
  logic        load_entry;

  assign f3    = instr[14:12];
  assign i_imm = {{21{instr[31]}}, instr[30:20]};
  assign s_imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
  assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  assign in_ready   = !out_valid || out_ready;
  assign load_entry = in_valid && in_ready && !flush;

  logic [2:0]  aluop_d, cmpop_d, alumux2_d;
  logic        load_regfile_d, dmem_read_d, dmem_write_d;
  logic        wbmux_d, cmpmux_d, alumux1_d, illegal_d;
  logic [31:0] imm_d;
  logic [21:0] ctrl_d;

  // Opcodes only override the fields they need; everything else keeps its default.
  always_comb begin
    aluop_d        = ALU_ADD;
    cmpop_d        = 3'b000;
    alumux2_d      = 3'd0;
    load_regfile_d = 1'b0;
    dmem_read_d    = 1'b0;
    dmem_write_d   = 1'b0;
    wbmux_d        = 1'b0;
    cmpmux_d       = 1'b0;
    alumux1_d      = 1'b0;
    illegal_d      = 1'b0;
    imm_d          = i_imm;
    case (instr[6:0])
      OP_LUI: begin
        load_regfile_d = 1'b1;
        alumux2_d      = 3'd1;
        imm_d          = u_imm;
      end
      OP_AUIPC: begin
        load_regfile_d = 1'b1;
        alumux1_d      = 1'b1;
        alumux2_d      = 3'd1;
        imm_d          = u_imm;
      end
      OP_JAL: begin
        load_regfile_d = 1'b1;
        alumux1_d      = 1'b1;
        alumux2_d      = 3'd4;
        imm_d          = j_imm;
      end
      OP_JALR: load_regfile_d = 1'b1;
      OP_BR: begin
        cmpop_d   = f3;
        alumux1_d = 1'b1;
        alumux2_d = 3'd2;
        imm_d     = b_imm;
        illegal_d = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LOAD: begin
        dmem_read_d    = 1'b1;
        wbmux_d        = 1'b1;
        load_regfile_d = 1'b1;
        illegal_d      = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        dmem_write_d = 1'b1;
        alumux2_d    = 3'd3;
        imm_d        = s_imm;
        illegal_d    = (f3 >= 3'b011);
      end
      OP_IMM, OP_REG: begin
        load_regfile_d = 1'b1;
        alumux2_d      = (instr[6:0] == OP_REG) ? 3'd5 : 3'd0;
        case (f3)
          3'b000: aluop_d = ((instr[6:0] == OP_REG) && instr[30]) ? ALU_SUB : ALU_ADD;
          3'b001: aluop_d = ALU_SLL;
          3'b010: begin
            cmpop_d  = CMP_BLT;
            cmpmux_d = (instr[6:0] == OP_IMM);
          end
          3'b011: begin
            cmpop_d  = CMP_BLTU;
            cmpmux_d = (instr[6:0] == OP_IMM);
          end
          3'b100: aluop_d = ALU_XOR;
          3'b101: aluop_d = instr[30] ? ALU_SRA : ALU_SRL;
          3'b110: aluop_d = ALU_OR;
          default: aluop_d = ALU_AND;
        endcase
      end
      OP_CSR:  illegal_d = 1'b1;
      default: illegal_d = 1'b1;
    endcase
    // An undecodable instruction must never write architectural or memory state.
    if (illegal_d) begin
      load_regfile_d = 1'b0;
      dmem_read_d    = 1'b0;
      dmem_write_d   = 1'b0;
    end
    ctrl_d = {instr[6:0], aluop_d, cmpop_d, load_regfile_d, dmem_read_d,
              dmem_write_d, wbmux_d, cmpmux_d, alumux1_d, alumux2_d};
  end

  // Flush wins over everything; a simultaneous consume and accept keeps the entry valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ctrl      <= '0;
      pc_out    <= '0;
      imm       <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      funct3    <= '0;
      illegal   <= 1'b0;
    end else begin
      if (flush)           out_valid <= 1'b0;
      else if (load_entry) out_valid <= 1'b1;
      else if (out_ready)  out_valid <= 1'b0;
      if (load_entry) begin
        ctrl    <= ctrl_d;
        pc_out  <= pc_in;
        imm     <= imm_d;
        rs1     <= instr[19:15];
        rs2     <= instr[24:20];
        rd      <= instr[11:7];
        funct3  <= f3;
        illegal <= illegal_d;
      end
    end
  end

endmodule
